// File: rtl/lstm_seq_ctrl_pkg.sv
// lstm_pkg: shared types for the LSTM sequence controller.
// Holds the FSM state enum, the sequence-id width and the BITWIDTH helper.
package lstm_pkg;

  localparam int SEQ_ID_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_RESULT,
    S_OUTPUT
  } state_e;

  function automatic int bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// lstm_seq_ctrl_if: token, network and result signals of the sequence controller.
// master = controller side, slave = environment (token source, network, sink).
interface lstm_seq_ctrl_if
  import lstm_pkg::*;
#(
  parameter int RAW_W  = 1,
  parameter int DATA_W = 288
);
  logic                in_valid;
  logic                in_ready;
  logic [RAW_W-1:0]    in_data;
  logic                net_reset;
  logic [RAW_W-1:0]    net_input;
  logic                net_new_sample;
  logic                net_data_ready;
  logic                net_dense_enable;
  logic                net_result_ready;
  logic [DATA_W-1:0]   net_output;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [SEQ_ID_W-1:0] out_seq_id;
  logic                err_timeout;
  logic                busy;

  modport master (
    input  in_valid, in_data, net_data_ready,
    input  net_result_ready, net_output, out_ready,
    output in_ready, net_reset, net_input,
    output net_new_sample, net_dense_enable,
    output out_valid, out_data, out_seq_id,
    output err_timeout, busy
  );

  modport slave (
    output in_valid, in_data, net_data_ready,
    output net_result_ready, net_output, out_ready,
    input  in_ready, net_reset, net_input,
    input  net_new_sample, net_dense_enable,
    input  out_valid, out_data, out_seq_id,
    input  err_timeout, busy
  );
endinterface

// File: rtl/lstm_seq_ctrl_fifo.sv
// lstm_in_fifo: token FIFO, DEPTH a power of 2; ports push_i/pop_i/data_i,
// data_o (head), full_o, empty_o. Push and pop may happen in the same cycle.
module lstm_in_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push;
  logic         do_pop;

  // extra pointer bit separates full from empty
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
  assign rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: buffers tokens, sequences the LSTM network per timestep and
// returns one dense result per SEQ_LEN tokens. Ports: clock, reset, bus (master).
// Optional watchdog on WAIT/RESULT: define LSTM_SEQ_TIMEOUT_EN.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int RAW_INPUT_BIT  = 1,
  parameter int SEQ_LEN        = 48,
  parameter int FIFO_DEPTH     = 16,
  parameter int QN             = 6,
  parameter int QM             = 11,
  parameter int FINAL_OUT_SIZE = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic           clock,
  input logic           reset,
  lstm_seq_ctrl_if.master bus
);
  localparam int BITWIDTH = bitwidth(QN, QM);
  localparam int DATA_W   = FINAL_OUT_SIZE * BITWIDTH;
  localparam int STEP_W   = $clog2(SEQ_LEN + 1);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(SEQ_LEN - 1);

  state_e                   state_q, state_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic                     cnt_q, cnt_d;
  logic                     dr_prev_q;
  logic [RAW_INPUT_BIT-1:0] tok_q;
  logic                     ns_q;
  logic [DATA_W-1:0]        res_q, res_d;
  logic [SEQ_ID_W-1:0]      seq_q, seq_d;

  logic                     pop;
  logic                     empty;
  logic                     full;
  logic [RAW_INPUT_BIT-1:0] head;
  logic                     rise;
  logic                     wd_hit;
  logic                     dense;
  logic                     err;

  lstm_in_fifo #(
    .W     (RAW_INPUT_BIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (bus.in_valid),
    .pop_i   (pop),
    .data_i  (bus.in_data),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // a level left high from the previous step is not a new completion
  assign rise = bus.net_data_ready && !dr_prev_q;

`ifdef LSTM_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q;
  logic            in_wd;

  assign in_wd  = (state_q == S_WAIT) || (state_q == S_RESULT);
  assign wd_hit = in_wd && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign wd_d   = (in_wd && !wd_hit) ? wd_q + WD_W'(1) : '0;
  assign err    = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_hit) err_q <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      cnt_q     <= 1'b0;
      dr_prev_q <= 1'b0;
      tok_q     <= '0;
      ns_q      <= 1'b0;
      res_q     <= '0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      dr_prev_q <= bus.net_data_ready;
      ns_q      <= pop;
      res_q     <= res_d;
      seq_q     <= seq_d;
      if (pop) tok_q <= head;
    end
  end

  // cnt_q times the two-cycle CLEAR and SETTLE windows
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = 1'b0;
    res_d   = res_q;
    seq_d   = seq_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        step_d = '0;
        if (cnt_q) state_d = S_ISSUE;
        else       cnt_d   = 1'b1;
      end
      S_ISSUE: begin
        if (!empty) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wd_hit)    state_d = S_CLEAR;
        else if (rise) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!cnt_q) begin
          cnt_d = 1'b1;
        end else if (step_q == LAST) begin
          state_d = S_RESULT;
        end else begin
          step_d  = step_q + STEP_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_RESULT: begin
        if (wd_hit) begin
          state_d = S_CLEAR;
        end else if (bus.net_result_ready) begin
          res_d   = bus.net_output;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) begin
          seq_d   = seq_q + SEQ_ID_W'(1);
          step_d  = '0;
          state_d = empty ? S_IDLE : S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // dense window opens once the last step index is reached
  always_comb begin
    pop   = (state_q == S_ISSUE) && !empty;
    dense = (step_q == LAST) &&
            (state_q inside {S_ISSUE, S_WAIT,
                             S_SETTLE, S_RESULT});
  end

  assign bus.in_ready         = !full;
  assign bus.net_reset        = (state_q == S_CLEAR);
  assign bus.net_input        = tok_q;
  assign bus.net_new_sample   = ns_q;
  assign bus.net_dense_enable = dense;
  assign bus.out_valid        = (state_q == S_OUTPUT);
  assign bus.out_data         = res_q;
  assign bus.out_seq_id       = seq_q;
  assign bus.err_timeout      = err;
  assign bus.busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb_lstm_seq_ctrl: directed bench with a small network model and scoreboards
// for tokens presented to the network and for result vectors.
module tb_lstm_seq_ctrl;
  localparam int SEQ = 4;
  localparam int DEP = 4;
  localparam int BW  = 18;
  localparam int FOS = 16;
  localparam int DW  = FOS * BW;

  typedef struct {
    logic [15:0]   seq;
    logic [BW-1:0] val;
  } res_t;

  logic clk;
  logic rst;
  logic [BW-1:0] lane;
  logic net_en;

  int checks;
  int fails;
  int ns_total;
  int ns_seq;
  int nr_total;
  int n_res;
  int pulses;
  int dly;
  logic nr_prev;
  logic de_prev;

  logic tok_exp [$];
  res_t res_exp [$];

  lstm_seq_ctrl_if #(.RAW_W(1), .DATA_W(DW)) bus ();

  lstm_seq_ctrl #(
    .SEQ_LEN        (SEQ),
    .FIFO_DEPTH     (DEP),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lanes(input logic [BW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < FOS; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  assign bus.net_output = lanes(lane);

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // network model: data_ready rises 3 cycles after each new_sample
  always @(negedge clk) begin
    if (rst || bus.net_reset) begin
      pulses = 0;
      dly = 0;
      bus.net_data_ready = 1'b0;
      bus.net_result_ready = 1'b0;
    end else begin
      if (bus.net_new_sample) begin
        pulses++;
        dly = 3;
        bus.net_data_ready = 1'b0;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0 && net_en) bus.net_data_ready = 1'b1;
      end
      bus.net_result_ready = net_en && bus.net_dense_enable &&
                             pulses == SEQ && bus.net_data_ready;
    end
  end

  // monitor and scoreboards
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.net_reset && !nr_prev) begin
        nr_total++;
        ns_seq = 0;
      end
      if (bus.net_dense_enable && !de_prev)
        chk("dense_rise_step", DW'(ns_seq), DW'(SEQ - 1));
      if (!bus.net_dense_enable && de_prev)
        chk("dense_fall_output", DW'(bus.out_valid), DW'(1));
      if (bus.net_new_sample) begin
        ns_total++;
        ns_seq++;
        if (tok_exp.size() == 0) begin
          chk("token_underflow", DW'(1), DW'(0));
        end else begin
          logic e;
          e = tok_exp.pop_front();
          chk("net_input", DW'(bus.net_input), DW'(e));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_res++;
        if (res_exp.size() == 0) begin
          chk("result_underflow", DW'(1), DW'(0));
        end else begin
          res_t r;
          r = res_exp.pop_front();
          chk("out_seq_id", DW'(bus.out_seq_id), DW'(r.seq));
          chk("out_data", bus.out_data, lanes(r.val));
        end
      end
    end
    nr_prev = bus.net_reset;
    de_prev = bus.net_dense_enable;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_tok(input logic d);
    int k;
    k = 0;
    while (!bus.in_ready && k < 400) begin
      cyc(1);
      k++;
    end
    chk("push_ready", DW'(bus.in_ready), DW'(1));
    bus.in_valid = 1'b1;
    bus.in_data = d;
    if (bus.in_ready) tok_exp.push_back(d);
    cyc(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic try_push(input logic d, output bit acc);
    acc = bus.in_ready;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    if (acc) tok_exp.push_back(d);
    cyc(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(input int target);
    for (int k = 0; k < 600 && n_res < target; k++) cyc(1);
    chk("result_count", DW'(n_res), DW'(target));
  endtask

  task automatic push_res(input logic [15:0] s, input logic [BW-1:0] v);
    res_t r;
    r.seq = s;
    r.val = v;
    res_exp.push_back(r);
  endtask

  initial begin
    bit acc;
    bit exp_acc [6];
    logic [5:0] pat6;
    logic [3:0] pat4;
    int base;
    int nrb;
    int k;

    checks = 0;
    fails = 0;
    ns_total = 0;
    ns_seq = 0;
    nr_total = 0;
    n_res = 0;
    nr_prev = 1'b0;
    de_prev = 1'b0;
    net_en = 1'b1;
    lane = 18'h15;
    bus.in_valid = 1'b0;
    bus.in_data = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    #2 rst = 1'b1;
    cyc(3);

    chk("rst_in_ready", DW'(bus.in_ready), DW'(1));
    chk("rst_net_reset", DW'(bus.net_reset), DW'(0));
    chk("rst_new_sample", DW'(bus.net_new_sample), DW'(0));
    chk("rst_dense", DW'(bus.net_dense_enable), DW'(0));
    chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_seq_id", DW'(bus.out_seq_id), DW'(0));
    chk("rst_err", DW'(bus.err_timeout), DW'(0));
    chk("rst_busy", DW'(bus.busy), DW'(0));
    rst = 1'b0;
    cyc(1);

    // one full sequence
    push_res(16'd0, 18'h15);
    pat4 = 4'b1101;
    for (int i = 0; i < 4; i++) push_tok(pat4[i]);
    wait_res(1);
    chk("seq0_samples", DW'(ns_total), DW'(4));
    for (k = 0; k < 20 && bus.busy; k++) cyc(1);
    chk("idle_after_seq0", DW'(bus.busy), DW'(0));

    // output backpressure, FIFO fills while stalled
    bus.out_ready = 1'b0;
    lane = 18'h2A;
    push_res(16'd1, 18'h2A);
    pat4 = 4'b0011;
    for (int i = 0; i < 4; i++) push_tok(pat4[i]);
    for (k = 0; k < 300 && !bus.out_valid; k++) cyc(1);
    chk("stall_out_valid", DW'(bus.out_valid), DW'(1));
    exp_acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    pat6 = 6'b110101;
    for (int i = 0; i < 6; i++) begin
      try_push(pat6[i], acc);
      chk("fill_accept", DW'(acc), DW'(exp_acc[i]));
    end
    chk("full_in_ready", DW'(bus.in_ready), DW'(0));
    lane = 18'h33;
    for (int i = 0; i < 20; i++) begin
      chk("hold_data", bus.out_data, lanes(18'h2A));
      chk("hold_seq", DW'(bus.out_seq_id), DW'(1));
      chk("hold_no_clear", DW'(bus.net_reset), DW'(0));
      cyc(1);
    end
    push_res(16'd2, 18'h33);
    bus.out_ready = 1'b1;
    wait_res(3);
    for (k = 0; k < 20 && bus.busy; k++) cyc(1);
    chk("idle_after_seq2", DW'(bus.busy), DW'(0));

    // nine tokens: two results, ninth starts a new sequence
    lane = 18'h07;
    push_res(16'd3, 18'h07);
    push_res(16'd4, 18'h07);
    for (int i = 0; i < 9; i++) push_tok(logic'(i % 3 == 0));
    wait_res(5);
    base = ns_total;
    nrb = nr_total;
    for (k = 0; k < 20 && ns_total == base; k++) cyc(1);
    chk("ninth_sample", DW'(ns_total), DW'(base + 1));
    chk("ninth_clear", DW'(nr_total), DW'(nrb + 1));
    chk("ninth_seq_id", DW'(bus.out_seq_id), DW'(5));

    // reset during WAIT at step 2
    push_tok(1'b1);
    push_tok(1'b0);
    for (k = 0; k < 100 && ns_seq < 3; k++) cyc(1);
    net_en = 1'b0;
    chk("step2_reached", DW'(ns_seq), DW'(3));
    cyc(5);
    chk("wait_busy", DW'(bus.busy), DW'(1));
    rst = 1'b1;
    cyc(1);
    chk("mid_in_ready", DW'(bus.in_ready), DW'(1));
    chk("mid_busy", DW'(bus.busy), DW'(0));
    chk("mid_seq_id", DW'(bus.out_seq_id), DW'(0));
    chk("mid_out_data", bus.out_data, '0);
    chk("mid_net_input", DW'(bus.net_input), DW'(0));
    chk("mid_new_sample", DW'(bus.net_new_sample), DW'(0));
    chk("mid_net_reset", DW'(bus.net_reset), DW'(0));
    tok_exp.delete();
    rst = 1'b0;
    net_en = 1'b1;
    cyc(1);

    lane = 18'h3FFFF;
    push_res(16'd0, 18'h3FFFF);
    nrb = nr_total;
    pat4 = 4'b0110;
    for (int i = 0; i < 4; i++) push_tok(pat4[i]);
    wait_res(6);
    chk("restart_clear", DW'(nr_total), DW'(nrb + 1));
    chk("restart_seq_id", DW'(bus.out_seq_id), DW'(1));

`ifdef LSTM_SEQ_TIMEOUT_EN
    for (k = 0; k < 20 && bus.busy; k++) cyc(1);
    net_en = 1'b0;
    push_tok(1'b1);
    for (k = 0; k < 30 && !bus.net_new_sample; k++) cyc(1);
    chk("to_sample", DW'(bus.net_new_sample), DW'(1));
    k = 0;
    while (!bus.err_timeout && k < 100) begin
      k++;
      cyc(1);
    end
    chk("to_cycles", DW'(k), DW'(16));
    chk("to_clear", DW'(bus.net_reset), DW'(1));
    chk("to_seq_id", DW'(bus.out_seq_id), DW'(1));
    cyc(5);
    chk("to_sticky", DW'(bus.err_timeout), DW'(1));
    chk("to_issue_wait", DW'(bus.busy), DW'(1));
`else
    cyc(5);
    chk("err_tied", DW'(bus.err_timeout), DW'(0));
`endif

    chk("results_left", DW'(res_exp.size()), DW'(0));
    rst = 1'b1;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
